avalon_mem_port: RTL
====================

# avalon_mem_port

Parametrised load/store bus port between the multicycle MIPS core's control FSM and the Avalon-MM master interface. It takes one byte, half, word or (64-bit builds) doubleword access request and generates the aligned bus address, `byteenable` and lane-shifted `writedata`. It honours `waitrequest` and returns sign- or zero-extended read data with a single-cycle completion pulse. It replaces the core's fixed full-word, no-wait bus wiring and provides the core's stall source for memory.

## Interface
- `DATA_W`, 32: bus data width; 32 or 64 only.
- `ADDR_W`, 32: byte-address width.
- `TIMEOUT`, 0: maximum `waitrequest` cycles before the access is abandoned with error; 0 disables the timeout.

- `clk`  in  1  single clock; all state on rising edge.
- `reset_i`  in  1  asynchronous, active-low reset.
- `req_i`  in  1  access request; sampled only in IDLE.
- `we_i`  in  1  1 = store, 0 = load.
- `size_i`  in  2  `access_size_t`: BYTE=0, HALF=1, WORD=2, DWORD=3 (DWORD is legal only when DATA_W=64).
- `signed_i`  in  1  load result is sign-extended when 1, zero-extended when 0.
- `addr_i`  in  ADDR_W  byte address.
- `wdata_i`  in  DATA_W  store data, right-aligned.
- `busy_o`  out  1  high in every state except IDLE; the core stalls on it.
- `done_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  valid with `done_o`: misaligned access, illegal size, or timeout.
- `rdata_o`  out  DATA_W  extended load result; holds until the next successful load.
- `address`  out  ADDR_W  Avalon address, aligned to DATA_W/8 bytes.
- `read`, `write`  out  1  Avalon strobes.
- `waitrequest`  in  1  Avalon slave stall.
- `writedata`  out  DATA_W  Avalon write data.
- `byteenable`  out  DATA_W/8  Avalon byte lanes.
- `readdata`  in  DATA_W  Avalon read data.

## Operation
- FSM states and transitions:
  - IDLE → ACCESS on `req_i` with a legal request.
  - IDLE → RESP on `req_i` with an illegal request (`err_o` set).
  - ACCESS → RESP when `waitrequest`=0.
  - ACCESS → RESP when the timeout expires (`err_o` set).
  - RESP → IDLE unconditionally.
- Request capture:
  - On acceptance, latch `we_i`, `size_i`, `signed_i`, the offset `addr_i[OFF_W-1:0]` (where OFF_W = log2(DATA_W/8)), and the aligned address.
  - A request is legal when the offset is a multiple of the access size in bytes and `size_i` is valid for DATA_W.
- Bus outputs are registered:
  - `byteenable` carries size-many ones shifted left by the offset. Example (DATA_W=32): HALF at offset 2 gives 4'b1100.
  - `writedata` is `wdata_i` shifted left by 8×offset; unused lanes are 0.
  - `read`/`write` are driven from the latched `we_i`.
- All bus outputs stay stable throughout ACCESS while `waitrequest`=1.
- Load completion: in the ACCESS cycle with `waitrequest`=0:
  - `readdata` is shifted right by 8×offset and masked to the access size.
  - The result is sign- or zero-extended to DATA_W and registered into `rdata_o`.
- Store completion: `rdata_o` is unchanged.
- Error completion: no bus cycle is issued for illegal requests; `rdata_o` is unchanged.
- Timeout:
  - A wait counter clears on entry to ACCESS and increments each cycle with `waitrequest`=1.
  - When it reaches TIMEOUT (and TIMEOUT≠0), the strobes drop and the FSM enters RESP with `err_o`.
- `req_i` is ignored outside IDLE. The core must hold the request fields only in the accepting cycle.

## Timing
- Reset values, asserted asynchronously on `reset_i` low, including mid-access:
  - State is IDLE.
  - All outputs are 0: `address`, `read`, `write`, `writedata`, `byteenable`, `rdata_o`, `busy_o`, `done_o`, `err_o`.
  - The wait counter is 0.
- Legal access, accepted at edge E0:
  - Strobes are high from E0 to E1.
  - With zero wait states, `waitrequest` is sampled low at E1, and `done_o` is high from E1 to E2.
  - Minimum latency is 2 cycles from acceptance to `done_o`; each wait state adds 1 cycle.
- Strobes fall on the same edge that `done_o` rises.
- Back-to-back accesses: the next request is accepted earliest at the edge after `done_o`, giving 3-cycle throughput.
- Illegal request accepted at E0: `done_o` and `err_o` are high from E0 to E1, with no strobe.
- `err_o` is 0 whenever `done_o` is 0.

## Structure
- The shared `codes` package gains:
  - `access_size_t`;
  - `mem_state_t` (IDLE, ACCESS, RESP);
  - a `size_bytes()` function.
- One sub-module, `mem_lane_align`, is combinational. It takes size, offset and signed as inputs and produces:
  - `byteenable`;
  - the store shift;
  - the load extract/extend.
- It is parametrised by DATA_W.

## Test plan
- DATA_W=32, LW at 0x100, `readdata`=0xDEADBEEF, no wait → `address`=0x100, `byteenable`=4'b1111, `rdata_o`=0xDEADBEEF, `done_o` 2 cycles after acceptance.
- LB signed at 0x103, `readdata`=0x80FF_0000 → `byteenable`=4'b1000, `rdata_o`=0xFFFF_FF80. The same access with LBU → 0x0000_0080.
- SH at 0x202, `wdata_i`=0x0000_1234, 3 wait cycles → `address`=0x200, `byteenable`=4'b1100, `writedata`=0x1234_0000; outputs are stable for all 4 strobe cycles and `done_o` arrives 5 cycles after acceptance.
- LW at 0x101 → `done_o`=`err_o`=1 one cycle after acceptance, `read` never asserted, `rdata_o` unchanged.
- TIMEOUT=4 with `waitrequest` held high → strobes drop after 4 wait cycles and `done_o`=`err_o`=1. Then `reset_i` is pulsed low during a second access → all outputs are 0 immediately and state is IDLE.
- DATA_W=64, DWORD at 0x8, then HALF at 0xE → `byteenable`=8'hFF, then 8'hC0; DWORD at 0x4 → error.

Source files
------------

// File: rtl/codes.sv
// Shared type and helper definitions for the core's load/store bus port.
package codes;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HALF  = 2'd1,
    WORD  = 2'd2,
    DWORD = 2'd3
  } access_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mem_state_t;

  function automatic logic [3:0] size_bytes(input access_size_t sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, store data shift, load extract and extend.
module mem_lane_align
  import codes::*;
#(
  parameter int DATA_W = 32,
  localparam int BE_W  = DATA_W / 8,
  localparam int OFF_W = $clog2(BE_W)
) (
  input  logic [1:0]        size_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              legal_o,
  output logic [BE_W-1:0]   be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o
);

  access_size_t      size;
  logic [3:0]        nbytes;
  logic [OFF_W-1:0]  align_mask;
  logic [OFF_W+2:0]  bit_shift;
  logic [BE_W-1:0]   lane_mask;
  logic [DATA_W-1:0] data_mask;
  logic [DATA_W-1:0] rd_shift;
  logic              sign_bit;

  assign size       = access_size_t'(size_i);
  assign nbytes     = size_bytes(size);
  assign align_mask = OFF_W'(nbytes - 4'd1);
  assign bit_shift  = {off_i, 3'b000};

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < BE_W; i++) lane_mask[i] = (i < int'(nbytes));
  end

  always_comb begin
    data_mask = '0;
    for (int i = 0; i < BE_W; i++) data_mask[8*i +: 8] = {8{lane_mask[i]}};
  end

  // DWORD only exists when the bus is wide enough to carry it in one beat.
  assign legal_o = ((size != DWORD) || (DATA_W == 64)) && ((off_i & align_mask) == '0);
  assign be_o    = lane_mask << off_i;
  assign wdata_o = (wdata_i & data_mask) << bit_shift;

  assign rd_shift = rdata_i >> bit_shift;

  always_comb begin
    case (size)
      BYTE:    sign_bit = rd_shift[7];
      HALF:    sign_bit = rd_shift[15];
      WORD:    sign_bit = rd_shift[31];
      default: sign_bit = rd_shift[DATA_W-1];
    endcase
  end

  assign rdata_o = (rd_shift & data_mask) | (~data_mask & {DATA_W{signed_i & sign_bit}});

endmodule

// File: rtl/avalon_mem_port.sv
// Load/store port between the core control FSM and an Avalon-MM master; stalls the core via busy_o.
module avalon_mem_port
  import codes::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [1:0]          size_i,
  input  logic                signed_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [1:0]          state_o,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  input  logic                waitrequest,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   readdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  mem_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic              signed_q, signed_d;
  logic [1:0]        size_q, size_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       wait_cnt_q, wait_cnt_d;

  logic              idle;
  logic [1:0]        lane_size;
  logic [OFF_W-1:0]  lane_off;
  logic              lane_signed;
  logic              lane_legal;
  logic [BE_W-1:0]   lane_be;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] lane_rdata;

  // The aligner sees the live request while idle and the captured one afterwards.
  assign idle        = (state_q == IDLE);
  assign lane_size   = idle ? size_i : size_q;
  assign lane_off    = idle ? addr_i[OFF_W-1:0] : off_q;
  assign lane_signed = idle ? signed_i : signed_q;

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .size_i   (lane_size),
    .off_i    (lane_off),
    .signed_i (lane_signed),
    .wdata_i  (wdata_i),
    .rdata_i  (readdata),
    .legal_o  (lane_legal),
    .be_o     (lane_be),
    .wdata_o  (lane_wdata),
    .rdata_o  (lane_rdata)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    signed_d   = signed_q;
    size_d     = size_q;
    off_d      = off_q;
    addr_d     = addr_q;
    read_d     = read_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    err_d      = 1'b0;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (lane_legal) begin
            state_d    = ACCESS;
            we_d       = we_i;
            signed_d   = signed_i;
            size_d     = size_i;
            off_d      = addr_i[OFF_W-1:0];
            addr_d     = {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            read_d     = ~we_i;
            write_d    = we_i;
            wdata_d    = lane_wdata;
            be_d       = lane_be;
            wait_cnt_d = '0;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (!waitrequest) begin
          state_d = RESP;
          read_d  = 1'b0;
          write_d = 1'b0;
          if (!we_q) rdata_d = lane_rdata;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
          if ((TIMEOUT != 0) && (wait_cnt_d == 32'(TIMEOUT))) begin
            state_d = RESP;
            read_d  = 1'b0;
            write_d = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      signed_q   <= 1'b0;
      size_q     <= '0;
      off_q      <= '0;
      addr_q     <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      signed_q   <= signed_d;
      size_q     <= size_d;
      off_q      <= off_d;
      addr_q     <= addr_d;
      read_q     <= read_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == RESP);
  assign err_o      = err_q;
  assign rdata_o    = rdata_q;
  assign state_o    = state_q;
  assign address    = addr_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = wdata_q;
  assign byteenable = be_q;

endmodule
